// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared opcode, ALU-select, FSM and instruction-field definitions.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_NAND = 2'b01;
  localparam logic [1:0] OP_LDI  = 2'b10;
  localparam logic [1:0] OP_OUT  = 2'b11;

  localparam logic SEL_ADD  = 1'b0;
  localparam logic SEL_NAND = 1'b1;

  localparam int         STATE_W = 2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 6;
  localparam int RD_MSB  = 5;
  localparam int RD_LSB  = 4;
  localparam int RS_MSB  = 1;
  localparam int RS_LSB  = 0;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

  function automatic logic [1:0] instr_opcode(input logic [7:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [1:0] instr_rd(input logic [7:0] instr);
    return instr[RD_MSB:RD_LSB];
  endfunction

  // Source register lives in the low two bits; bits [3:2] are don't-care.
  function automatic logic [1:0] instr_rs(input logic [7:0] instr);
    return instr[RS_MSB:RS_LSB];
  endfunction

  function automatic logic [3:0] instr_imm(input logic [7:0] instr);
    return instr[IMM_MSB:IMM_LSB];
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_ctrl_if.sv
// ============================================================================
// Module   : alu_ctrl_if
// Brief    : Instruction handshake, ALU operand/result and OUT port bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface alu_ctrl_if #(
  parameter int DW = 4
) ();

  logic [7:0]    INSTR;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] ALU_A;
  logic [DW-1:0] ALU_B;
  logic          ALU_SEL;
  logic [DW-1:0] ALU_RES;
  logic [DW-1:0] OUT_DATA;
  logic          out_valid;
  logic          Z;

  // master: instruction source plus the external ALU; slave: alu_ctrl.
  modport master (
    output INSTR, instr_valid, ALU_RES,
    input  instr_ready, ALU_A, ALU_B, ALU_SEL, OUT_DATA, out_valid, Z
  );

  modport slave (
    input  INSTR, instr_valid, ALU_RES,
    output instr_ready, ALU_A, ALU_B, ALU_SEL, OUT_DATA, out_valid, Z
  );

endinterface

`default_nettype wire

// File: rtl/regfile_4x4.sv
// ============================================================================
// Module   : regfile_4x4
// Brief    : Register file, two combinational reads and one synchronous write.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_4x4 #(
  parameter  int DW   = 4,
  parameter  int NREG = 4,
  localparam int AW   = $clog2(NREG)
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic [AW-1:0] ra_addr,
  output logic      [DW-1:0] ra_data,
  input  wire logic [AW-1:0] rb_addr,
  output logic      [DW-1:0] rb_data,
  input  wire logic          we,
  input  wire logic [AW-1:0] wa,
  input  wire logic [DW-1:0] wd
);

  logic [DW-1:0] r_mem [NREG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[wa] <= wd;
    end
  end

  assign ra_data = r_mem[ra_addr];
  assign rb_data = r_mem[rb_addr];

endmodule

`default_nettype wire

// File: rtl/alu_ctrl.sv
// ============================================================================
// Module   : alu_ctrl
// Brief    : Multi-cycle controller driving an external 4-bit add/NAND ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_ctrl
  import cpu_pkg::*;
#(
  parameter int DW   = 4,
  parameter int NREG = 4
) (
  input wire logic clk,
  input wire logic rst_n,
  alu_ctrl_if.slave bus
);

  localparam int AW = $clog2(NREG);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next_state;

  logic          r_ready;
  logic          w_accept;
  logic          w_is_alu_op;
  logic          w_start_alu;
  logic          w_do_ldi;
  logic          w_do_out;
  logic          w_do_wb;

  logic [1:0]    w_opc;
  logic [AW-1:0] w_rd;
  logic [AW-1:0] w_rs;
  logic [DW-1:0] w_imm;
  logic [DW-1:0] w_rd_data;
  logic [DW-1:0] w_rs_data;

  logic          w_we;
  logic [AW-1:0] w_wa;
  logic [DW-1:0] w_wd;

  logic [AW-1:0] r_wb_rd;
  logic [DW-1:0] r_alu_a;
  logic [DW-1:0] r_alu_b;
  logic          r_alu_sel;
  logic [DW-1:0] r_out_data;
  logic          r_out_valid;
  logic          r_z;

  assign w_opc       = instr_opcode(bus.INSTR);
  assign w_rd        = instr_rd(bus.INSTR);
  assign w_rs        = instr_rs(bus.INSTR);
  assign w_imm       = instr_imm(bus.INSTR);
  assign w_accept    = bus.instr_valid & r_ready;
  assign w_is_alu_op = (w_opc == OP_ADD) || (w_opc == OP_NAND);

  regfile_4x4 #(
    .DW   (DW),
    .NREG (NREG)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (w_rd),
    .ra_data (w_rd_data),
    .rb_addr (w_rs),
    .rb_data (w_rs_data),
    .we      (w_we),
    .wa      (w_wa),
    .wd      (w_wd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && w_is_alu_op) w_next_state = ST_EXEC;
      ST_EXEC: w_next_state = ST_WB;
      ST_WB:   w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_start_alu = 1'b0;
    w_do_ldi    = 1'b0;
    w_do_out    = 1'b0;
    w_do_wb     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_start_alu = w_accept && w_is_alu_op;
        w_do_ldi    = w_accept && (w_opc == OP_LDI);
        w_do_out    = w_accept && (w_opc == OP_OUT);
      end
      ST_WB:   w_do_wb = 1'b1;
      default: ;
    endcase
    // LDI and writeback never coincide: nothing is accepted outside IDLE.
    w_we = w_do_ldi | w_do_wb;
    w_wa = w_do_wb ? r_wb_rd     : w_rd;
    w_wd = w_do_wb ? bus.ALU_RES : w_imm;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ready     <= 1'b0;
      r_wb_rd     <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= SEL_ADD;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_z         <= 1'b0;
    end else begin
      r_ready     <= (w_next_state == ST_IDLE);
      r_out_valid <= w_do_out;
      if (w_start_alu) begin
        r_alu_a   <= w_rd_data;
        r_alu_b   <= w_rs_data;
        r_alu_sel <= (w_opc == OP_NAND) ? SEL_NAND : SEL_ADD;
        r_wb_rd   <= w_rd;
      end
      if (w_do_out) begin
        r_out_data <= w_rd_data;
      end
      if (w_do_wb) begin
        r_z <= (bus.ALU_RES == '0);
      end
    end
  end

  assign bus.instr_ready = r_ready;
  assign bus.ALU_A       = r_alu_a;
  assign bus.ALU_B       = r_alu_b;
  assign bus.ALU_SEL     = r_alu_sel;
  assign bus.OUT_DATA    = r_out_data;
  assign bus.out_valid   = r_out_valid;
  assign bus.Z           = r_z;

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl.sv
// ============================================================================
// Module   : tb_alu_ctrl
// Brief    : Self-checking bench for alu_ctrl with an in-bench behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_ctrl_if #(.DW(4)) bus ();

  alu_ctrl #(
    .DW   (4),
    .NREG (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External combinational ALU: add when sel=0, NAND when sel=1.
  assign bus.ALU_RES = bus.ALU_SEL ? ~(bus.ALU_A & bus.ALU_B) : (bus.ALU_A + bus.ALU_B);

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mk(input logic [1:0] op, input logic [1:0] rd, input logic [3:0] lo);
    return {op, rd, lo};
  endfunction

  // ---------------- behavioural model ----------------
  logic [3:0] m_reg [4];
  logic       m_ready, m_ov, m_z, m_sel;
  logic [3:0] m_od, m_a, m_b, m_pend;
  logic [1:0] m_pend_rd;
  logic [7:0] m_ins;
  int         m_busy;
  logic [7:0] acc_q  [$];
  logic [7:0] sent_q [$];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_reg[i] = 4'h0;
      m_ready = 0; m_ov = 0; m_z = 0; m_sel = 0;
      m_a = 0; m_b = 0; m_od = 0; m_busy = 0;
    end else begin
      m_ov = 0;
      if (m_busy == 2) begin
        m_busy = 1;
      end else if (m_busy == 1) begin
        m_reg[m_pend_rd] = m_pend;
        m_z     = (m_pend == 4'h0);
        m_busy  = 0;
        m_ready = 1;
      end else if (m_ready && bus.instr_valid) begin
        m_ins = bus.INSTR;
        acc_q.push_back(m_ins);
        case (m_ins[7:6])
          2'b10: m_reg[m_ins[5:4]] = m_ins[3:0];
          2'b11: begin m_od = m_reg[m_ins[5:4]]; m_ov = 1; end
          default: begin
            m_a       = m_reg[m_ins[5:4]];
            m_b       = m_reg[m_ins[1:0]];
            m_sel     = (m_ins[7:6] == 2'b01);
            m_pend    = m_sel ? ~(m_a & m_b) : 4'(m_a + m_b);
            m_pend_rd = m_ins[5:4];
            m_busy    = 2;
            m_ready   = 0;
          end
        endcase
      end else begin
        m_ready = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("instr_ready", bus.instr_ready, m_ready);
      check("out_valid",   bus.out_valid,   m_ov);
      if (m_ov) check("out_data", bus.OUT_DATA, m_od);
      check("z",       bus.Z,       m_z);
      check("alu_a",   bus.ALU_A,   m_a);
      check("alu_b",   bus.ALU_B,   m_b);
      check("alu_sel", bus.ALU_SEL, m_sel);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] ins);
    int n = 0;
    bus.instr_valid = 1'b1;
    while (!bus.instr_ready && n < 20) begin
      bus.INSTR = 8'($urandom);
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("accept_timeout", bus.instr_ready, 1);
    bus.INSTR = ins;
    sent_q.push_back(ins);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.instr_valid = 1'b0;
    bus.INSTR       = 8'($urandom);
    repeat (n) @(negedge clk);
  endtask

  task automatic out_lit(input string name, input logic [1:0] rd, input logic [3:0] exp);
    send(mk(2'b11, rd, 4'h0));
    check({name, "_valid"}, bus.out_valid, 1);
    check(name, bus.OUT_DATA, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.instr_valid = 1'b1;
    bus.INSTR       = mk(2'b10, 2'd0, 4'hF);
    rst_n           = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_ready", bus.instr_ready, 0);
    @(negedge clk);
    check("rst_ready2", bus.instr_ready, 0);
    check("rst_ovalid", bus.out_valid, 0);
    check("rst_z", bus.Z, 0);
    rst_n = 1'b1;
    idle(1);
    check("ready_after_rst", bus.instr_ready, 1);
    for (int r = 0; r < 4; r++) out_lit("rst_reg", 2'(r), 4'h0);

    // Load then output, back to back
    send(mk(2'b10, 2'd2, 4'h9));
    out_lit("ldi_out", 2'd2, 4'h9);
    idle(1);
    check("ovalid_pulse", bus.out_valid, 0);

    // ADD with wrap-around
    send(mk(2'b10, 2'd0, 4'hF));
    send(mk(2'b10, 2'd1, 4'h1));
    send(mk(2'b00, 2'd0, 4'h1));
    check("exec_a", bus.ALU_A, 4'hF);
    check("exec_b", bus.ALU_B, 4'h1);
    check("exec_sel", bus.ALU_SEL, 0);
    check("exec_ready", bus.instr_ready, 0);
    idle(1);
    check("wb_ready", bus.instr_ready, 0);
    idle(1);
    check("wrap_ready", bus.instr_ready, 1);
    check("wrap_z", bus.Z, 1);
    out_lit("wrap_r0", 2'd0, 4'h0);

    // NAND with aliasing; rs bits [3:2] carry junk
    send(mk(2'b10, 2'd3, 4'hA));
    send(mk(2'b01, 2'd3, 4'b1111));
    check("nand_sel", bus.ALU_SEL, 1);
    out_lit("nand_r3", 2'd3, 4'h5);
    check("nand_z", bus.Z, 0);
    send(mk(2'b00, 2'd3, 4'h3));
    out_lit("add_alias_r3", 2'd3, 4'hA);
    send(mk(2'b10, 2'd1, 4'h7));
    send(mk(2'b00, 2'd1, 4'h1));
    out_lit("add_r1_r1", 2'd1, 4'hE);

    // Reset during EXEC aborts the writeback
    send(mk(2'b10, 2'd0, 4'h3));
    send(mk(2'b10, 2'd1, 4'h4));
    send(mk(2'b00, 2'd0, 4'h1));
    rst_n = 1'b0;
    idle(1);
    check("midrst_ready", bus.instr_ready, 0);
    rst_n = 1'b1;
    idle(1);
    check("midrst_ready_back", bus.instr_ready, 1);
    out_lit("midrst_r0", 2'd0, 4'h0);
    out_lit("midrst_r1", 2'd1, 4'h0);

    // Streaming with instr_valid held high
    send(mk(2'b10, 2'd1, 4'h5));
    send(mk(2'b10, 2'd2, 4'h3));
    send(mk(2'b00, 2'd1, 4'h2));
    out_lit("stream_r1", 2'd1, 4'h8);
    send(mk(2'b01, 2'd2, 4'h1));
    out_lit("stream_r2", 2'd2, 4'hF);
    idle(2);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        rst_n = 1'b0;
        idle($urandom_range(1, 2));
        rst_n = 1'b1;
      end else if ($urandom_range(0, 3) == 0) begin
        idle($urandom_range(1, 2));
      end else begin
        send(8'($urandom));
      end
    end
    idle(4);

    check("accept_count", acc_q.size(), sent_q.size());
    for (int i = 0; i < sent_q.size() && i < acc_q.size(); i++)
      check("accept_order", acc_q[i], sent_q[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
